fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end feeding the IF/ID pipeline register of the core.
//  Owns the fetch PC and drives a synchronous instruction memory (1-cycle read).
//  Buffers returned {pc, instr} pairs in a DEPTH-entry FIFO so decode stalls
//  do not drop fetches. Branch redirects from EX flush the FIFO and any in-flight read.
// PARAMETERS
//  PC_W      9   program-counter / instruction-memory address width (byte address)
//  INS_W     32  instruction width
//  DEPTH     4   FIFO entries; power of two, >= 2
//  RESET_PC  0   fetch PC loaded on reset
// PORTS
//  clk          in   1                  clock, all state updates on rising edge
//  reset        in   1                  synchronous, active-high
//  redirect     in   1                  taken branch / flush request from EX
//  redirect_pc  in   PC_W               restart address, sampled when redirect=1
//  imem_req     out  1                  read issued this cycle
//  imem_addr    out  PC_W               read address (= fetch_pc)
//  imem_rdata   in   INS_W              data for the request of the previous cycle
//  out_valid    out  1                  head entry valid toward IF/ID
//  out_pc       out  PC_W               PC of head entry
//  out_instr    out  INS_W              instruction of head entry
//  out_ready    in   1                  IF/ID accepts head (= !stall)
//  count        out  $clog2(DEPTH)+1    current FIFO occupancy
// BEHAVIOUR
//  State: fetch_pc, inflight (1b) + inflight_pc, FIFO storage, rd/wr ptrs, count.
//  Reset (priority over all): fetch_pc=RESET_PC, inflight=0, count=0, ptrs=0.
//  Outputs during reset cycle: imem_req=0, out_valid=0, count=0.
//  Outputs out_pc/out_instr are don't-care when out_valid=0.
//  Issue: imem_req = !reset & !redirect & (count + inflight < DEPTH).
//  On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4, mod 2^PC_W.
//  No issue: inflight<=0.
//  Push: when inflight=1 and no redirect, write {inflight_pc, imem_rdata} at wr ptr.
//  Pop: out_valid & out_ready; out_valid = (count!=0) & !redirect.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//  Credit rule: never overflows, because issue reserves a slot for the inflight read.
//  Full + inflight: no further issue until a pop; at most DEPTH entries held.
//  Pointers wrap modulo DEPTH.
//  Redirect cycle:
//   - no issue, no push (inflight data discarded), no pop.
//   - next cycle: count=0, inflight=0, fetch_pc=redirect_pc.
//  After redirect: first req at redirect_pc in the cycle after; out_valid 2 cycles later.
//  Latency: issue at cycle N -> pushed end of N+1 -> out_valid at N+2 (empty FIFO).
//  Throughput: 1 instr/cycle sustained when out_ready=1.
//  redirect_pc is not alignment-checked; bits [1:0] pass through unchanged.
// TESTING
//  1 Reset, then release with out_ready=1
//    -> imem_req=1, addr 0x000 at cycle 0; out_valid at cycle 2
//    -> out_pc 0x000, 0x004, 0x008 on consecutive cycles.
//  2 Hold out_ready=0 from cycle 0
//    -> count reaches 4; imem_req stays 0 once count+inflight=4
//    -> release out_ready: pops pc 0x000, 0x004, 0x008, 0x00C in order, none lost.
//  3 FIFO full with inflight read, pulse redirect with redirect_pc=0x040
//    -> next cycle count=0, imem_addr=0x040
//    -> first out_pc=0x040 two cycles later; stale instr never appears.
//  4 Redirect to 0x1FC
//    -> out_pc sequence 0x1FC, 0x000, 0x004 (PC wrap-around).
//  5 out_ready toggling 1/0 each cycle in steady state
//    -> count bounded in 1..DEPTH; outputs in strict PC order
//    -> simultaneous push/pop leaves count unchanged.
//  6 Assert reset while FIFO holds 3 entries and a read is inflight
//    -> next cycle out_valid=0, count=0; restart fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end feeding the IF/ID pipeline register.
//   It owns the fetch PC and issues reads to a synchronous instruction memory
//   with a one-cycle read latency. Each returned {pc, instr} pair is buffered in
//   a DEPTH-entry FIFO, so decode stalls do not drop fetches. A redirect flushes
//   the FIFO and discards any read that is still in flight.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   redirect, redirect_pc taken-branch flush request and its restart address
//   imem_req, imem_addr   read strobe and address sent to instruction memory
//   imem_rdata            read data for the request issued in the previous cycle
//   out_valid, out_pc,    head entry presented to IF/ID
//   out_instr
//   out_ready             IF/ID accepts the head entry
//   count                 current FIFO occupancy
module fetch_queue #(
  parameter int unsigned     PC_W     = 9,
  parameter int unsigned     INS_W    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INS_W-1:0]         imem_rdata,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [INS_W-1:0]         out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PC_W-1:0]  pc_mem    [DEPTH];
  logic [INS_W-1:0] instr_mem [DEPTH];

  logic [CNT_W:0]   credits_used;
  logic             issue;
  logic             push;
  logic             pop;

  // An issued read reserves its FIFO slot up front, so the occupancy plus the
  // read in flight can never exceed DEPTH and a push never finds the FIFO full.
  assign credits_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue        = !reset && !redirect && (credits_used < (CNT_W+1)'(DEPTH));
  assign push         = !reset && !redirect && inflight_q;
  assign out_valid    = !reset && !redirect && (count_q != '0);
  assign pop          = out_valid && out_ready;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign out_pc    = pc_mem[rd_ptr_q];
  assign out_instr = instr_mem[rd_ptr_q];
  assign count     = reset ? '0 : count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_W'(4);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= inflight_pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
